lp_tree_deserializer: RTL

LP_TREE_DESERIALIZER -- requirements
Module: lp_tree_deserializer

---
 rtl/lp_deser_pkg.sv | 19 +
 rtl/lp_deser_out_buf.sv | 55 +++++
 rtl/lp_tree_deserializer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/lp_deser_pkg.sv
// Shared types and constants for the LSB-first serial-to-parallel deserializer.
package lp_deser_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        SYNCED = 1'b1
    } state_e;

    localparam int              WORD_W        = 16;
    localparam logic [15:0]     SYNC_WORD_DEF = 16'hF0A5;
    localparam int              BIT_CNT_W     = 4;
    localparam logic [3:0]      BIT_CNT_LAST  = 4'd15;

    // Gap counter must be able to hold MAX_GAP itself.
    function automatic int gap_cnt_w(input int max_gap);
        return (max_gap < 1) ? 1 : $clog2(max_gap + 1);
    endfunction

endpackage

// File: rtl/lp_deser_out_buf.sv
// One-entry valid/ready word buffer; a word arriving while full and not drained is dropped
// and latches a sticky overflow flag.
module lp_deser_out_buf #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         overflow_o
);

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         ovf_q, ovf_d;
    logic         accept;

    always_comb begin
        accept  = valid_q & ready_i;
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (load_i) begin
            // A drain on the same edge frees the slot for the new word.
            if (!valid_q || accept) begin
                data_d  = data_i;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/lp_tree_deserializer.sv
// Serial-to-parallel deserializer with marker-based word alignment (HUNT/SYNCED).
// Optional marker-gap supervision is built when LP_DESER_GAP_CHECK_EN is defined.
module lp_tree_deserializer
    import lp_deser_pkg::*;
#(
    parameter int          OUTPUTS_NUM = 16,
    parameter logic [15:0] SYNC_WORD   = SYNC_WORD_DEF,
    parameter int          MAX_GAP     = 64
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   SERIAL_IN,
    input  logic                   RESYNC,
    output logic [OUTPUTS_NUM-1:0] PAR_OUT,
    output logic                   PAR_VALID,
    input  logic                   PAR_READY,
    output logic                   LOCKED,
    output logic                   OVERFLOW,
    output logic                   LOCK_LOST
);

    if (OUTPUTS_NUM != WORD_W || MAX_GAP < 1) begin : g_bad_cfg
        $error("lp_tree_deserializer: unsupported OUTPUTS_NUM or MAX_GAP");
    end

    state_e                 state_q, state_d;
    logic [OUTPUTS_NUM-1:0] shift_q, shift_d;
    logic [BIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   word_load;

`ifdef LP_DESER_GAP_CHECK_EN
    localparam int GAP_W = gap_cnt_w(MAX_GAP);
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             lock_lost_q, lock_lost_d;
`endif

    always_comb begin
        shift_d   = {SERIAL_IN, shift_q[OUTPUTS_NUM-1:1]};
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_load = 1'b0;
`ifdef LP_DESER_GAP_CHECK_EN
        gap_d       = gap_q;
        lock_lost_d = 1'b0;
`endif
        if (RESYNC) begin
            state_d = HUNT;
            cnt_d   = '0;
`ifdef LP_DESER_GAP_CHECK_EN
            gap_d   = '0;
`endif
        end else begin
            case (state_q)
                HUNT: begin
                    if (shift_d == SYNC_WORD) begin
                        state_d = SYNCED;
                        cnt_d   = '0;
                    end
                end
                SYNCED: begin
                    cnt_d = cnt_q + BIT_CNT_W'(1);
                    if (cnt_q == BIT_CNT_LAST) begin
                        if (shift_d == SYNC_WORD) begin
`ifdef LP_DESER_GAP_CHECK_EN
                            gap_d = '0;
`endif
                        end else begin
`ifdef LP_DESER_GAP_CHECK_EN
                            // Too many words without a marker: distrust alignment and drop this one.
                            if (gap_q == GAP_W'(MAX_GAP)) begin
                                state_d     = HUNT;
                                cnt_d       = '0;
                                gap_d       = '0;
                                lock_lost_d = 1'b1;
                            end else begin
                                gap_d     = gap_q + GAP_W'(1);
                                word_load = 1'b1;
                            end
`else
                            word_load = 1'b1;
`endif
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= HUNT;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef LP_DESER_GAP_CHECK_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            gap_q       <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            gap_q       <= gap_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign LOCK_LOST = lock_lost_q;
`else
    assign LOCK_LOST = 1'b0;
`endif

    assign LOCKED = (state_q == SYNCED);

    lp_deser_out_buf #(
        .W (OUTPUTS_NUM)
    ) u_out_buf (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .load_i     (word_load),
        .data_i     (shift_d),
        .ready_i    (PAR_READY),
        .data_o     (PAR_OUT),
        .valid_o    (PAR_VALID),
        .overflow_o (OVERFLOW)
    );

endmodule
